// File: rtl/turf_generic_narb.sv
// Round-robin N-port to single-master bus arbiter with per-transaction timeout.
// One transaction is in flight at a time: IDLE grants, ISSUE waits for the master, DONE acks the port.
module turf_generic_narb #(
    parameter int NPORTS  = 4,
    parameter int ADDR_W  = 28,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NPORTS-1:0]          s_en_i,
    input  logic [NPORTS-1:0]          s_wr_i,
    input  logic [NPORTS*ADDR_W-1:0]   s_adr_i,
    input  logic [NPORTS*DATA_W-1:0]   s_dat_i,
    output logic [NPORTS-1:0]          s_ack_o,
    output logic [NPORTS-1:0]          s_err_o,
    output logic [DATA_W-1:0]          s_dat_o,
    output logic                       m_en_o,
    output logic                       m_wr_o,
    input  logic                       m_ack_i,
    output logic [ADDR_W-1:0]          m_adr_o,
    output logic [DATA_W-1:0]          m_dat_o,
    input  logic [DATA_W-1:0]          m_dat_i,
    output logic                       busy_o,
    output logic [$clog2(NPORTS)-1:0]  cur_port_o
);

    localparam int PW = $clog2(NPORTS);
    localparam int CW = 16;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]    state;
    logic [PW-1:0] last_q;
    logic [CW-1:0] to_cnt;
    logic [PW-1:0] pick;
    logic          pick_vld;
    logic [PW:0]   cand;

    // Walk from farthest to nearest so the port closest after last_q overrides the rest.
    always_comb begin
        pick     = last_q;
        pick_vld = 1'b0;
        cand     = '0;
        for (int i = NPORTS; i >= 1; i--) begin
            cand = {1'b0, last_q} + (PW+1)'(i);
            if (cand >= (PW+1)'(NPORTS)) begin
                cand = cand - (PW+1)'(NPORTS);
            end
            if (s_en_i[cand[PW-1:0]]) begin
                pick     = cand[PW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    assign m_en_o = (state == ST_ISSUE);
    assign busy_o = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            last_q     <= PW'(NPORTS - 1);
            cur_port_o <= '0;
            to_cnt     <= '0;
            m_wr_o     <= 1'b0;
            m_adr_o    <= '0;
            m_dat_o    <= '0;
            s_ack_o    <= '0;
            s_err_o    <= '0;
            s_dat_o    <= '0;
        end else begin
            s_ack_o <= '0;
            s_err_o <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        state      <= ST_ISSUE;
                        last_q     <= pick;
                        cur_port_o <= pick;
                        to_cnt     <= '0;
                        m_wr_o     <= s_wr_i[pick];
                        m_adr_o    <= s_adr_i[int'(pick)*ADDR_W +: ADDR_W];
                        m_dat_o    <= s_dat_i[int'(pick)*DATA_W +: DATA_W];
                    end
                end
                ST_ISSUE: begin
                    // A master ack always beats an expiring timeout in the same cycle.
                    if (m_ack_i) begin
                        state   <= ST_DONE;
                        s_ack_o <= {{(NPORTS-1){1'b0}}, 1'b1} << last_q;
                        if (!m_wr_o) begin
                            s_dat_o <= m_dat_i;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        state   <= ST_DONE;
                        s_ack_o <= {{(NPORTS-1){1'b0}}, 1'b1} << last_q;
                        s_err_o <= {{(NPORTS-1){1'b0}}, 1'b1} << last_q;
                        if (!m_wr_o) begin
                            s_dat_o <= '1;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/turf_generic_narb.md
TURF_GENERIC_NARB -- requirements
Module: turf_generic_narb

Interface
REQ-001 SHALL have parameter NPORTS, default 4: number of requester ports, legal range 2..8.
REQ-002 SHALL have parameter ADDR_W, default 28: address width per port.
REQ-003 SHALL have parameter DATA_W, default 32: data width.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum ISSUE cycles without m_ack_i, legal range 2..65535.
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 s_en_i  in  NPORTS  per-port request, held high until that port's s_ack_o.
REQ-008 s_wr_i  in  NPORTS  per-port write (1) / read (0).
REQ-009 s_adr_i  in  NPORTS*ADDR_W  per-port address, port p at [p*ADDR_W +: ADDR_W].
REQ-010 s_dat_i  in  NPORTS*DATA_W  per-port write data, port p at [p*DATA_W +: DATA_W].
REQ-011 s_ack_o  out  NPORTS  one-cycle completion pulse, one-hot.
REQ-012 s_err_o  out  NPORTS  one-cycle timeout flag, coincident with s_ack_o.
REQ-013 s_dat_o  out  DATA_W  read data, shared by all ports.
REQ-014 m_en_o / m_wr_o  out  1 each  master request / direction.
REQ-015 m_ack_i  in  1  master completion.
REQ-016 m_adr_o  out  ADDR_W; m_dat_o out DATA_W; m_dat_i in DATA_W.
REQ-017 busy_o  out  1  high in any state other than IDLE.
REQ-018 cur_port_o  out  $clog2(NPORTS)  index of port most recently granted.

Function
REQ-019 FSM SHALL have states IDLE, ISSUE and DONE.
REQ-020 IDLE, any s_en_i bit high: SHALL grant one port by round-robin, register its wr/adr/dat onto m_wr_o/m_adr_o/m_dat_o, and enter ISSUE next cycle.
REQ-021 Round-robin: search SHALL start at (last granted + 1) mod NPORTS; after reset, last granted = NPORTS-1, so port 0 has top priority.
REQ-022 ISSUE: m_en_o SHALL be 1, with m_wr_o/m_adr_o/m_dat_o held constant.
REQ-023 ISSUE with m_ack_i=1: SHALL enter DONE; on a read, s_dat_o SHALL capture m_dat_i in the same edge.
REQ-024 DONE: s_ack_o[g]=1 for exactly one cycle, m_en_o=0, then IDLE; min request-to-request period = 3 cycles + master latency.
REQ-025 ISSUE cycle counter SHALL reset on ISSUE entry; when it reaches TIMEOUT-1 with no m_ack_i, SHALL enter DONE with s_err_o[g]=1 and, on reads, s_dat_o all-ones.
REQ-026 m_ack_i and timeout in same cycle: ack SHALL win, s_err_o=0.
REQ-027 m_ack_i outside ISSUE SHALL be ignored.
REQ-028 Granted port deasserting s_en_i during ISSUE: transaction SHALL still complete and s_ack_o[g] still pulse.
REQ-029 s_en_i on non-granted ports during ISSUE/DONE SHALL be held pending, never dropped and never acked.
REQ-030 s_dat_o SHALL hold its value until the next read completion; writes leave it unchanged.
REQ-031 cur_port_o SHALL update on grant and hold through IDLE.

Reset
REQ-032 rst low SHALL asynchronously force IDLE, m_en_o=0, m_wr_o=0, m_adr_o=0, m_dat_o=0, s_ack_o=0, s_err_o=0, s_dat_o=0, busy_o=0, cur_port_o=0, timeout counter 0, last granted = NPORTS-1.
REQ-033 Reset mid-ISSUE SHALL abort with no s_ack_o pulse; the first grant after release SHALL take one clk edge after rst rises.

Verification
REQ-034 NPORTS=4, all s_en_i held high, master acks 2 cycles after m_en_o -> grants in order 0,1,2,3,0, one s_ack_o pulse each.
REQ-035 Port 2 read, adr 0x0ABCDEF, master returns 0x12345678 -> m_adr_o=0x0ABCDEF, s_dat_o=0x12345678 from DONE onward, s_ack_o=4'b0100.
REQ-036 TIMEOUT=4, master never acks -> m_en_o high exactly 4 cycles, s_ack_o and s_err_o pulse together, s_dat_o=0xFFFFFFFF.
REQ-037 TIMEOUT=4, ack in last ISSUE cycle -> s_ack_o pulse, s_err_o=0, captured data valid.
REQ-038 rst low two cycles into ISSUE -> m_en_o=0 immediately, no s_ack_o; port 0 regranted first after release.
REQ-039 Port 1 drops s_en_i during ISSUE while port 3 requests -> port 1 still acked, port 3 granted next.
